parsed_msg_fifo: RTL
====================

Name: parsed_msg_fifo

Overview:
Synchronous show-ahead (first-word-fall-through) buffer between the message parser and the order book.
- The parser pushes one parsed_msg_t per cycle.
- The order book pops with read_en/empty and sees the head message on parsed_message with zero read latency.
- Adds overflow/underflow accounting and occupancy telemetry, so that drops under burst load are observable.

Parameters:
- DEPTH, 16, number of message slots; must be a power of two, at least 2.
- ALMOST_FULL_MARGIN, 2, almost_full asserts when free slots ≤ this value; range 1..DEPTH-1.
- CNT_W, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  parser push strobe.
- wr_msg  in  parsed_msg_t  message to push.
- full  out  1  no free slot.
- almost_full  out  1  free slots ≤ ALMOST_FULL_MARGIN; parser backpressure hint.
- read_en  in  1  order book pop strobe; consumes the current head.
- parsed_message  out  parsed_msg_t  head message, valid when empty=0.
- empty  out  1  no stored message.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- high_water  out  $clog2(DEPTH)+1  maximum count since reset.
- overflow_cnt  out  CNT_W  pushes dropped because full; saturates at all-ones.
- underflow  out  1  sticky; set by read_en while empty.

Behaviour:
- **Clock and reset:** one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- **Reset values:** pointers=0, count=0, empty=1, full=0, almost_full=0, high_water=0, overflow_cnt=0, underflow=0. Storage array is not reset.
- **Pointers:** wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - Flags, count and almost_full are registered, derived from next-state pointers; never combinational from inputs.
- **parsed_message:** combinational read of mem[rd_ptr low bits]. Driven to all-zero whenever empty=1, so downstream never sees stale data.
- **Push:** wr_en=1 and (full=0, or full=1 with read_en=1) → mem[wr_ptr]<=wr_msg, wr_ptr++.
  - A message pushed at edge N is visible on parsed_message, and empty=0, after edge N.
- **Pop:** read_en=1 and empty=0 → rd_ptr++. The next head is visible after the same edge.
- **Simultaneous push+pop:**
  - Not empty, not full: both occur; count unchanged.
  - Full: pop frees the slot and the push is accepted in the same cycle; count stays DEPTH; no overflow increment.
  - Empty: push is accepted, the pop is ignored, count becomes 1, and underflow is set.
- **Overflow:** wr_en=1, full=1, read_en=0 → message dropped, pointers unchanged, overflow_cnt++ saturating at 2^CNT_W-1.
- **Underflow:** read_en=1 while empty=1 → no pointer change; underflow <= 1, sticky until reset.
- **high_water:** updated each cycle to max(high_water, next count).
- **Wrap-around:** pointers wrap modulo 2*DEPTH. Ordering is strictly FIFO across wrap; no message is lost or duplicated.
- **Reset mid-operation:** all stored content is discarded on the reset edge. A wr_en/read_en coincident with reset is ignored. empty=1 in the first cycle after reset.
- **No internal message filtering or field interpretation:** messages pass bit-exact.

Decomposition:
- parsed_msg_t, the MSG_* type encodings and the ORDER_SIDE_* encodings stay in the shared parser_defs package; nothing new is added to it.
- FIFO-local widths (pointer width, count width) are localparams inside the module.
- One natural sub-module: fifo_ptr_ctrl, holding pointer/flag/count logic parameterised by DEPTH. It is reusable by other buffers in the datapath.
- Storage array and telemetry stay in the top module.

Test Plan (DEPTH=4, ALMOST_FULL_MARGIN=1):
1. **Single message:** push ADD id=0x11111111 BID price=1000 qty=10 → empty=0 the next cycle; parsed_message equals the pushed struct bit-exact; count=1. Pop → empty=1, parsed_message=0.
2. **Fill to full:** push 4 messages, ids 1..4 → almost_full=1 at count=3, full=1 at count=4. 5th push → dropped, overflow_cnt=1. Pops return ids 1,2,3,4 in order; high_water=4.
3. **Full with simultaneous push+pop:** at full, push id=5 together with a pop → id 1 consumed, id 5 accepted, count=4, overflow_cnt unchanged. Drain order is 2,3,4,5.
4. **Underflow:** read_en while empty → underflow=1, count=0. Same-cycle push of UPDATE id=0xBBBBBBBB ASK price=1075 qty=11 → count=1, head=that message.
5. **Wrap stress:** 20 back-to-back push+pop pairs with ids 0..19 after a 2-deep prefill → output sequence is contiguous, count stays 2, no overflow, no underflow.
6. **Reset mid-operation:** with count=3, assert reset for 1 cycle together with wr_en → count=0, empty=1, high_water=0, overflow_cnt=0. Subsequent push/pop works normally.

Source files
------------

// File: rtl/parser_defs.sv
// Shared parser definitions: message type and side encodings plus the parsed message record
// exchanged between the parser, the message FIFO and the order book.
package parser_defs;

  typedef enum logic [1:0] {
    MSG_ADD    = 2'd0,
    MSG_UPDATE = 2'd1,
    MSG_DELETE = 2'd2,
    MSG_TRADE  = 2'd3
  } msg_type_t;

  typedef enum logic {
    ORDER_SIDE_BID = 1'b0,
    ORDER_SIDE_ASK = 1'b1
  } order_side_t;

  typedef struct packed {
    msg_type_t   msg_type;
    order_side_t side;
    logic [31:0] order_id;
    logic [31:0] price;
    logic [31:0] qty;
  } parsed_msg_t;

endpackage

// File: rtl/parsed_msg_fifo_if.sv
// Push/pop handshake between the parser (write side), the FIFO and the order book (read side).
interface parsed_msg_fifo_if;
  import parser_defs::*;

  logic        wr_en;
  parsed_msg_t wr_msg;
  logic        full;
  logic        almost_full;
  logic        read_en;
  parsed_msg_t parsed_message;
  logic        empty;

  modport master (
    output wr_en, wr_msg, read_en,
    input  full, almost_full, parsed_message, empty
  );

  modport slave (
    input  wr_en, wr_msg, read_en,
    output full, almost_full, parsed_message, empty
  );

endinterface

// File: rtl/parsed_msg_fifo_ptr_ctrl.sv
// Reusable FIFO pointer/flag/occupancy controller: wrap-bit pointers, with every flag
// registered from the next-state pointers.
module fifo_ptr_ctrl #(
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_MARGIN = 2,
  localparam int ADDR_W            = $clog2(DEPTH),
  localparam int PTR_W             = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [PTR_W-1:0]  count,
  output logic [PTR_W-1:0]  count_nxt
);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;

  // A pop at full frees the slot the same-cycle push lands in.
  assign push = wr_en && (!full || rd_en);
  assign pop  = rd_en && !empty;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(push);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      empty       <= (wr_ptr_nxt == rd_ptr_nxt);
      full        <= (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                     (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
      almost_full <= (count_nxt >= PTR_W'(DEPTH - ALMOST_FULL_MARGIN));
    end
  end

endmodule

// File: rtl/parsed_msg_fifo.sv
// Show-ahead message buffer between the parser and the order book, with drop and
// occupancy telemetry so burst losses are observable.
module parsed_msg_fifo
  import parser_defs::*;
#(
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_MARGIN = 2,
  parameter int CNT_W              = 16,
  localparam int ADDR_W            = $clog2(DEPTH),
  localparam int PTR_W             = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  parsed_msg_fifo_if.slave     bus,
  output logic [PTR_W-1:0]     count,
  output logic [PTR_W-1:0]     high_water,
  output logic [CNT_W-1:0]     overflow_cnt,
  output logic                 underflow
);

  parsed_msg_t       mem [DEPTH];
  logic              push, pop;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [PTR_W-1:0]  count_nxt;

  fifo_ptr_ctrl #(
    .DEPTH              (DEPTH),
    .ALMOST_FULL_MARGIN (ALMOST_FULL_MARGIN)
  ) u_ptr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (bus.wr_en),
    .rd_en       (bus.read_en),
    .push        (push),
    .pop         (pop),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .empty       (bus.empty),
    .full        (bus.full),
    .almost_full (bus.almost_full),
    .count       (count),
    .count_nxt   (count_nxt)
  );

  // NOTE: storage has no reset; the pointers alone decide which slots hold valid data.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_addr] <= bus.wr_msg;
  end

  assign bus.parsed_message = bus.empty ? '0 : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      high_water   <= '0;
      overflow_cnt <= '0;
      underflow    <= 1'b0;
    end else begin
      if (count_nxt > high_water) high_water <= count_nxt;
      if (bus.wr_en && bus.full && !bus.read_en && (overflow_cnt != '1))
        overflow_cnt <= overflow_cnt + CNT_W'(1);
      if (bus.read_en && bus.empty) underflow <= 1'b1;
    end
  end

endmodule
